// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the CPU load/store path.
// Accepts one request at a time, waits WAIT_STATES cycles, performs a single
// byte/half/word access on the owned RAM, and returns extended load data and
// an error flag on a valid/ready response channel.
module dmem_responder #(
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      MEM_ADDR_BITS = 10,
    parameter logic [DATA_WIDTH-1:0]   BASE_ADDR     = 32'h0001_0000,
    parameter int                      WAIT_STATES   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << MEM_ADDR_BITS;

    // One past the last valid byte address; one extra bit so the compare
    // cannot wrap when the window touches the top of the address space.
    localparam logic [DATA_WIDTH:0] LIMIT_ADDR =
        {1'b0, BASE_ADDR} + (DATA_WIDTH + 1)'(DEPTH * NUM_LANES);

    // Counter value loaded on acceptance; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [3:0]              cnt_reg;
    logic [3:0]              cnt_next;
    logic                    access_en;

    // Captured request fields
    logic                    we_reg;
    logic [1:0]              size_reg;
    logic                    unsigned_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    // Fields used by the access edge (live inputs or captured copy)
    logic                    acc_we;
    logic [1:0]              acc_size;
    logic [DATA_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;

    logic                    acc_bad_shape;
    logic                    acc_out_of_range;
    logic                    acc_err;
    logic [MEM_ADDR_BITS-1:0] acc_idx;
    logic [NUM_LANES-1:0]    acc_be;
    logic [NUM_LANES-1:0]    wr_en;
    logic [DATA_WIDTH-1:0]   acc_wdata_rep;

    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic                    err_reg;
    logic                    load_ok_reg;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [DATA_WIDTH-1:0]   load_ext;

    // With no wait states the access happens on the acceptance edge, so it
    // must see the request inputs directly rather than the captured copy.
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign acc_we    = req_we_i;
            assign acc_size  = req_size_i;
            assign acc_addr  = req_addr_i;
            assign acc_wdata = req_wdata_i;
        end else begin : g_captured
            assign acc_we    = we_reg;
            assign acc_size  = size_reg;
            assign acc_addr  = addr_reg;
            assign acc_wdata = wdata_reg;
        end
    endgenerate

    // State register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; also decides which edge performs the RAM access
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access_en  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (WAIT_STATES == 0) begin
                        access_en  = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access_en  = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: handshakes follow the state; data is gated so that idle,
    // store and error responses read back as zero
    always_comb begin
        req_ready_o = (state_reg == S_IDLE);
        rsp_valid_o = (state_reg == S_RESP);
        rsp_err_o   = err_reg;
        rsp_rdata_o = load_ok_reg ? load_ext : '0;
    end

    // Request capture on acceptance; data-only, needs no reset
    always_ff @(posedge clk) begin
        if (req_valid_i && req_ready_o) begin
            we_reg       <= req_we_i;
            size_reg     <= req_size_i;
            unsigned_reg <= req_unsigned_i;
            addr_reg     <= req_addr_i;
            wdata_reg    <= req_wdata_i;
        end
    end

    // Error classification: illegal size, misalignment, or outside the window.
    // Addresses below the base are rejected rather than wrapping onto the RAM.
    always_comb begin
        case (acc_size)
            2'b00:   acc_bad_shape = 1'b0;
            2'b01:   acc_bad_shape = acc_addr[0];
            2'b10:   acc_bad_shape = |acc_addr[1:0];
            default: acc_bad_shape = 1'b1;
        endcase
        acc_out_of_range = ({1'b0, acc_addr} < {1'b0, BASE_ADDR}) ||
                           ({1'b0, acc_addr} >= LIMIT_ADDR);
        acc_err = acc_bad_shape || acc_out_of_range;
        acc_idx = MEM_ADDR_BITS'((acc_addr - BASE_ADDR) >> 2);
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        case (acc_size)
            2'b00: begin
                acc_be        = 4'b0001 << acc_addr[1:0];
                acc_wdata_rep = {NUM_LANES{acc_wdata[7:0]}};
            end
            2'b01: begin
                acc_be        = 4'b0011 << acc_addr[1:0];
                acc_wdata_rep = {2{acc_wdata[15:0]}};
            end
            default: begin
                acc_be        = 4'b1111;
                acc_wdata_rep = acc_wdata;
            end
        endcase
        wr_en = acc_be & {NUM_LANES{access_en & acc_we & ~acc_err}};
    end

    // One byte-wide RAM per lane so each lane has its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // Lane write and registered read, both on the access edge only
            always_ff @(posedge clk) begin
                if (access_en) begin
                    if (wr_en[gi]) begin
                        mem[acc_idx] <= acc_wdata_rep[gi*8 +: 8];
                    end
                    rd_byte_reg <= mem[acc_idx];
                end
            end

            assign ram_rdata[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // Response status registered on the access edge, cleared on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else if (access_en) begin
            err_reg     <= acc_err;
            load_ok_reg <= ~acc_we & ~acc_err;
        end else if (state_reg == S_RESP && rsp_ready_i) begin
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end
    end

    // Lane extraction and sign/zero extension of the registered RAM word.
    // Inputs are all registered and frozen in RESP, so the result is stable.
    always_comb begin
        load_byte = ram_rdata[{addr_reg[1:0], 3'b000} +: 8];
        load_half = addr_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_reg)
            2'b00: begin
                if (unsigned_reg) begin
                    load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
                end else begin
                    load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
                end
            end
            2'b01: begin
                if (unsigned_reg) begin
                    load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
                end else begin
                    load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
                end
            end
            default: begin
                load_ext = ram_rdata;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has one wait state, instance 1 has
// three. Table vectors, back-pressure and reset sequences, and random
// traffic checked against a byte-addressed memory model.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic [1:0]  req_size    [2];
    logic        req_unsigned[2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_rdata   [2];
    logic        rsp_err     [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem_m [4096];

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_STATES(1)) dut0 (
        .clk(clk), .rst(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_size_i(req_size[0]),
        .req_unsigned_i(req_unsigned[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]),
        .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_size_i(req_size[1]),
        .req_unsigned_i(req_unsigned[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]),
        .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1])
    );

    typedef struct {
        string       name;
        bit          we;
        bit [1:0]    size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, bit we, bit [1:0] sz, bit u,
                                logic [31:0] a, logic [31:0] w,
                                logic [31:0] r, bit e);
        vec_t v;
        v.name = n; v.we = we; v.size = sz; v.uns = u;
        v.addr = a; v.wdata = w; v.exp_rdata = r; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, plain arithmetic for extension
    task automatic model_txn(input bit we, input bit [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output bit err);
        longint a;
        longint n;
        longint v;
        int     off;
        a = longint'(addr);
        n = longint'(1) << size;
        err = (size == 2'd3) || (a % n != 0) || (a < longint'(BASE)) ||
              (a >= longint'(BASE) + 4096);
        rdata = 32'h0;
        if (!err) begin
            off = int'(a - longint'(BASE));
            if (we) begin
                for (int k = 0; k < n; k++) mem_m[off + k] = wdata[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(mem_m[off + k]) << (8 * k));
                if (!uns && n < 4 && v[8*n - 1]) v = v - (longint'(1) << (8 * n));
                rdata = v[31:0];
            end
        end
    endtask

    // One full request/response transaction on instance k; called #1 after
    // a rising edge with the instance idle
    task automatic do_txn(input int k, input string tag, input bit we, input bit [1:0] size,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input logic [31:0] exp_rdata, input bit exp_err);
        int guard;
        int lat;
        int exp_lat;
        logic [31:0] got_rdata;
        logic        got_err;
        exp_lat = (k == 0) ? 2 : 4;
        req_we[k] = we; req_size[k] = size; req_unsigned[k] = uns;
        req_addr[k] = addr; req_wdata[k] = wdata; req_valid[k] = 1'b1;
        guard = 0;
        while (req_ready[k] !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_accept"}, 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        got_rdata = rsp_rdata[k];
        got_err   = rsp_err[k];
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(rsp_valid[k]), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata[k], exp_rdata);
            check({tag, "_hold_ready"}, 32'(req_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        check({tag, "_release"}, {30'd0, rsp_valid[k], req_ready[k]}, 32'd1);
        $display("txn %s k=%0d we=%0d sz=%0d u=%0d addr=%h wd=%h -> rd=%h err=%0d lat=%0d",
                 tag, k, we, size, uns, addr, wdata, got_rdata, got_err, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_rdata;
        bit          m_err;
        logic [31:0] a;
        logic [31:0] d;
        bit          we;
        bit          uns;
        bit [1:0]    sz;
        int          mode;

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_size[k] = 2'd0; req_unsigned[k] = 1'b0; req_addr[k] = 32'h0;
            req_wdata[k] = 32'h0; rsp_ready[k] = 1'b0;
        end
        #1;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check("reset_req_ready", 32'(req_ready[k]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            check("reset_rsp_err",   32'(rsp_err[k]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Fill the random-traffic window (first 64 bytes) with known words
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            model_txn(1'b1, 2'd2, 1'b0, BASE + 32'(4 * w), d, m_rdata, m_err);
            do_txn(0, "init", 1'b1, 2'd2, 1'b0, BASE + 32'(4 * w), d, 0, 32'h0, 1'b0);
        end

        vecs.push_back(mk("sw_word",  1, 2, 0, 32'h0001_0008, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk("lw_word",  0, 2, 0, 32'h0001_0008, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("sw_ext",   1, 2, 0, 32'h0001_0000, 32'h80FF7F01, 32'h0, 0));
        vecs.push_back(mk("lb",       0, 0, 0, 32'h0001_0003, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu",      0, 0, 1, 32'h0001_0003, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk("lh",       0, 1, 0, 32'h0001_0002, 32'h0, 32'hFFFF80FF, 0));
        vecs.push_back(mk("lhu",      0, 1, 1, 32'h0001_0000, 32'h0, 32'h00007F01, 0));
        vecs.push_back(mk("lb_pos",   0, 0, 0, 32'h0001_0001, 32'h0, 32'h0000007F, 0));
        vecs.push_back(mk("sw_pre",   1, 2, 0, 32'h0001_0010, 32'h11223344, 32'h0, 0));
        vecs.push_back(mk("sb",       1, 0, 0, 32'h0001_0011, 32'hFFFFFFAA, 32'h0, 0));
        vecs.push_back(mk("sh",       1, 1, 0, 32'h0001_0012, 32'h1234BEEF, 32'h0, 0));
        vecs.push_back(mk("lw_part",  0, 2, 0, 32'h0001_0010, 32'h0, 32'hBEEFAA44, 0));
        vecs.push_back(mk("e_lh_odd", 0, 1, 0, 32'h0001_0001, 32'h0, 32'h0, 1));
        vecs.push_back(mk("e_sw_mis", 1, 2, 0, 32'h0001_0002, 32'h12345678, 32'h0, 1));
        vecs.push_back(mk("e_lw_low", 0, 2, 0, 32'h0000_FFFC, 32'h0, 32'h0, 1));
        vecs.push_back(mk("e_lw_hi",  0, 2, 0, 32'h0001_1000, 32'h0, 32'h0, 1));
        vecs.push_back(mk("e_ld_sz3", 0, 3, 0, 32'h0001_0008, 32'h0, 32'h0, 1));
        vecs.push_back(mk("e_st_sz3", 1, 3, 0, 32'h0001_0008, 32'h55555555, 32'h0, 1));
        vecs.push_back(mk("e_sb_hi",  1, 0, 0, 32'h0001_1000, 32'h00000077, 32'h0, 1));
        vecs.push_back(mk("e_lw_wrap",0, 2, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1));
        vecs.push_back(mk("lw_chk0",  0, 2, 0, 32'h0001_0000, 32'h0, 32'h80FF7F01, 0));
        vecs.push_back(mk("lw_chk8",  0, 2, 0, 32'h0001_0008, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("sw_last",  1, 2, 0, 32'h0001_0FFC, 32'hA5A55A5A, 32'h0, 0));
        vecs.push_back(mk("lw_last",  0, 2, 0, 32'h0001_0FFC, 32'h0, 32'hA5A55A5A, 0));
        vecs.push_back(mk("lhu_last", 0, 1, 1, 32'h0001_0FFE, 32'h0, 32'h0000A5A5, 0));
        vecs.push_back(mk("lb_last",  0, 0, 0, 32'h0001_0FFF, 32'h0, 32'hFFFFFFA5, 0));

        foreach (vecs[i]) begin
            model_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                      vecs[i].wdata, m_rdata, m_err);
            do_txn(0, vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns,
                   vecs[i].addr, vecs[i].wdata, 0, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Back-pressure: response held 5 cycles, second request waits
        req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h0001_0008; req_valid[0] = 1'b1;
        check("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_addr[0] = 32'h0001_0010;
        check("bp_wait_ready", 32'(req_ready[0]), 32'd0);
        check("bp_wait_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        check("bp_resp_valid", 32'(rsp_valid[0]), 32'd1);
        check("bp_resp_rdata", rsp_rdata[0], 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_hold_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("bp_hold_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("bp_hs_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_hs_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("bp_acc2_ready", 32'(req_ready[0]), 32'd0);
        check("bp_acc2_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        check("bp_resp2_valid", 32'(rsp_valid[0]), 32'd1);
        check("bp_resp2_rdata", rsp_rdata[0], 32'hBEEFAA44);
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("bp_end_ready", 32'(req_ready[0]), 32'd1);
        $display("txn backpressure k=0 held 5 cycles, second load accepted after handshake");

        // Random traffic against the model
        for (int t = 0; t < 200; t++) begin
            mode = int'($urandom % 10);
            if (mode < 8)       a = BASE + ($urandom % 64);
            else if (mode == 8) a = BASE - 32'd1 - ($urandom % 16);
            else                a = BASE + 32'd4096 + ($urandom % 32);
            we  = 1'($urandom % 2);
            uns = 1'($urandom % 2);
            sz  = 2'($urandom % 4);
            d   = $urandom;
            model_txn(we, sz, uns, a, d, m_rdata, m_err);
            do_txn(0, "rand", we, sz, uns, a, d, int'($urandom % 3), m_rdata, m_err);
        end

        // Reset during the second WAIT cycle drops the pending store
        do_txn(1, "r_pre_sw", 1'b1, 2'd2, 1'b0, 32'h0001_0020, 32'h01234567, 0, 32'h0, 1'b0);
        do_txn(1, "r_pre_lw", 1'b0, 2'd2, 1'b0, 32'h0001_0020, 32'h0, 0, 32'h01234567, 1'b0);
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h0001_0020; req_wdata[1] = 32'hCAFEF00D; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("rst_wait1_ready", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        check("rst_wait2_ready", 32'(req_ready[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        check("rst_async_ready", 32'(req_ready[1]), 32'd1);
        check("rst_async_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_async_rdata", rsp_rdata[1], 32'h0);
        check("rst_async_err",   32'(rsp_err[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        do_txn(1, "r_post_lw", 1'b0, 2'd2, 1'b0, 32'h0001_0020, 32'h0, 0, 32'h01234567, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
